// File: rtl/key_pkg.sv
// Shared types and default timing for the key_repeat slice.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } key_state_t;

`ifdef SIM
  localparam int unsigned KEY_DELAY_CYCLES = 6;
  localparam int unsigned KEY_RATE_CYCLES  = 3;
  localparam int unsigned KEY_CNT_BITS     = 4;
`else
  localparam int unsigned KEY_DELAY_CYCLES = 16_250_000;
  localparam int unsigned KEY_RATE_CYCLES  = 5_000_000;
  localparam int unsigned KEY_CNT_BITS     = 24;
`endif

endpackage

// File: rtl/key_edge.sv
// Registered rise/fall detector for a clean, synchronous key level.
// Ports: Clk, Reset (sync, active-high), key_in (level), key_d (delayed
// level), rise / fall (one-cycle registered edge strobes).
module key_edge (
  input  logic Clk,
  input  logic Reset,
  input  logic key_in,
  output logic key_d,
  output logic rise,
  output logic fall
);

  // Edge strobes are registered so that the downstream output registers
  // see them one cycle after the level was sampled.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      key_d <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      key_d <= key_in;
      rise  <= key_in & ~key_d;
      fall  <= ~key_in & key_d;
    end
  end

endmodule

// File: rtl/key_repeat.sv
// Turns a debounced button level into press/release/typematic-repeat pulses.
// Ports: Clk, Reset (sync, active-high), KeyClean (level), RepeatEn,
// KeyPress / KeyRelease / KeyRepeat / KeyEvent (one-cycle pulses), KeyHeld.
module key_repeat
  import key_pkg::*;
#(
  parameter int unsigned DELAY_CYCLES = KEY_DELAY_CYCLES,
  parameter int unsigned RATE_CYCLES  = KEY_RATE_CYCLES,
  parameter int unsigned CNT_BITS     = KEY_CNT_BITS
) (
  input  logic Clk,
  input  logic Reset,
  input  logic KeyClean,
  input  logic RepeatEn,
  output logic KeyPress,
  output logic KeyRelease,
  output logic KeyRepeat,
  output logic KeyEvent,
  output logic KeyHeld
);

  localparam logic [CNT_BITS-1:0] DELAY_LOAD = CNT_BITS'(DELAY_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] RATE_LOAD  = CNT_BITS'(RATE_CYCLES - 1);

  logic                key_d;
  logic                rise;
  logic                fall;
  key_state_t          state;
  key_state_t          state_nxt;
  logic [CNT_BITS-1:0] count;
  logic [CNT_BITS-1:0] count_nxt;
  logic                press_nxt;
  logic                release_nxt;
  logic                repeat_nxt;

  key_edge u_edge (
    .Clk    (Clk),
    .Reset  (Reset),
    .key_in (KeyClean),
    .key_d  (key_d),
    .rise   (rise),
    .fall   (fall)
  );

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    press_nxt   = rise;
    release_nxt = fall;
    repeat_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          count_nxt = DELAY_LOAD;
          state_nxt = DELAY;
        end
      end
      DELAY, REPEAT: begin
        // A release takes priority over an expiring count.
        if (fall) begin
          state_nxt = IDLE;
        end else if (count == '0) begin
          count_nxt  = RATE_LOAD;
          state_nxt  = REPEAT;
          repeat_nxt = RepeatEn;
        end else begin
          count_nxt = count - CNT_BITS'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      count      <= '0;
      KeyPress   <= 1'b0;
      KeyRelease <= 1'b0;
      KeyRepeat  <= 1'b0;
      KeyEvent   <= 1'b0;
      KeyHeld    <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      KeyPress   <= press_nxt;
      KeyRelease <= release_nxt;
      KeyRepeat  <= repeat_nxt;
      KeyEvent   <= press_nxt | repeat_nxt;
      KeyHeld    <= key_d;
    end
  end

endmodule
